// File: rtl/inference_param.sv
// inference_param: parametrised linear-classifier inference engine (arg-max + per-class score stream).
// Build option: define INFER_SATURATE_EN for saturating accumulate/bias add; default is two's-complement wrap.
module inference_param #(
  parameter int NUM_CLASSES = 10,
  parameter int NUM_INPUTS  = 784,
  parameter int WEIGHT_W    = 8,
  parameter int PIXEL_W     = 8,
  parameter int BIAS_W      = 32,
  parameter int ACC_W       = 32
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        weights_ready,
  input  logic                                        start,
  input  logic                                        abort,
  output logic [$clog2(NUM_CLASSES*NUM_INPUTS)-1:0]   weight_addr,
  input  logic [WEIGHT_W-1:0]                         weight_data,
  output logic [$clog2(NUM_CLASSES)-1:0]              bias_addr,
  input  logic [BIAS_W-1:0]                           bias_data,
  output logic [$clog2(NUM_INPUTS)-1:0]               input_addr,
  input  logic [PIXEL_W-1:0]                          input_pixel,
  output logic                                        busy,
  output logic                                        inference_done,
  output logic [$clog2(NUM_CLASSES)-1:0]              predicted_class,
  output logic [ACC_W-1:0]                            best_score,
  output logic                                        score_valid,
  output logic [$clog2(NUM_CLASSES)-1:0]              score_class,
  output logic [ACC_W-1:0]                            score
);

  localparam int CW = $clog2(NUM_CLASSES);
  localparam int IW = $clog2(NUM_INPUTS);
  localparam int AW = $clog2(NUM_CLASSES*NUM_INPUTS);
  localparam int PW = WEIGHT_W + PIXEL_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_BIAS,
    S_COMPUTE,
    S_DRAIN,
    S_ADD_BIAS,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [CW-1:0]           cls;
  logic [AW-1:0]           wnext;
  logic [1:0]              drain_cnt;
  logic                    rd_valid;
  logic                    op_valid;
  logic                    prod_valid;
  logic [WEIGHT_W-1:0]     weight_reg;
  logic [PIXEL_W-1:0]      pixel_reg;
  logic [BIAS_W-1:0]       bias_reg;
  logic signed [PW-1:0]    product;
  logic signed [PW-1:0]    w_ext;
  logic signed [PW-1:0]    p_ext;
  logic signed [ACC_W-1:0] prod_acc;
  logic signed [ACC_W-1:0] bias_acc;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] run_best;
  logic signed [ACC_W-1:0] best_next;
  logic [CW-1:0]           run_class;
  logic [CW-1:0]           class_next;
  logic                    last_input;
  logic                    last_class;
  logic                    better;

  function automatic logic signed [ACC_W-1:0] acc_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
`ifdef INFER_SATURATE_EN
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    // Top two sum bits disagree only on overflow; the top bit is the true sign.
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
`else
    return a + b;
`endif
  endfunction

  assign w_ext    = PW'($signed(weight_reg));
  assign p_ext    = PW'({1'b0, pixel_reg});
  assign prod_acc = ACC_W'(product);
  assign bias_acc = ACC_W'($signed(bias_reg));

  assign last_input = (input_addr == IW'(NUM_INPUTS - 1));
  assign last_class = (cls == CW'(NUM_CLASSES - 1));
  assign better     = (cls == '0) || (acc > run_best);
  assign best_next  = better ? acc : run_best;
  assign class_next = better ? cls : run_class;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:      if (start && weights_ready && !abort) state_next = S_LOAD_BIAS;
      S_LOAD_BIAS: state_next = S_COMPUTE;
      S_COMPUTE:   if (last_input) state_next = S_DRAIN;
      S_DRAIN:     if (drain_cnt == 2'd2) state_next = S_ADD_BIAS;
      S_ADD_BIAS:  state_next = S_COMPARE;
      S_COMPARE:   state_next = last_class ? S_DONE : S_LOAD_BIAS;
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
    if (state != S_IDLE && abort) state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cls             <= '0;
      wnext           <= '0;
      drain_cnt       <= '0;
      rd_valid        <= 1'b0;
      op_valid        <= 1'b0;
      prod_valid      <= 1'b0;
      weight_reg      <= '0;
      pixel_reg       <= '0;
      bias_reg        <= '0;
      product         <= '0;
      acc             <= '0;
      run_best        <= '0;
      run_class       <= '0;
      weight_addr     <= '0;
      bias_addr       <= '0;
      input_addr      <= '0;
      inference_done  <= 1'b0;
      predicted_class <= '0;
      best_score      <= '0;
      score_valid     <= 1'b0;
      score_class     <= '0;
      score           <= '0;
    end else begin
      score_valid    <= 1'b0;
      inference_done <= 1'b0;

      // Three-stage MAC: memory read -> operand regs -> product -> accumulate.
      rd_valid   <= (state == S_COMPUTE);
      op_valid   <= rd_valid;
      prod_valid <= op_valid;
      if (rd_valid) begin
        weight_reg <= weight_data;
        pixel_reg  <= input_pixel;
      end
      if (op_valid)   product <= w_ext * p_ext;
      if (prod_valid) acc     <= acc_add(acc, prod_acc);

      unique case (state)
        S_IDLE: begin
          if (state_next == S_LOAD_BIAS) begin
            cls       <= '0;
            bias_addr <= '0;
            wnext     <= '0;
          end
        end
        S_LOAD_BIAS: begin
          rd_valid   <= 1'b0;
          op_valid   <= 1'b0;
          prod_valid <= 1'b0;
          weight_reg <= '0;
          pixel_reg  <= '0;
          product    <= '0;
          acc        <= '0;
          if (state_next == S_COMPUTE) begin
            input_addr  <= '0;
            weight_addr <= wnext;
            wnext       <= wnext + 1'b1;
          end
        end
        S_COMPUTE: begin
          drain_cnt <= '0;
          // input_addr is 0 only on the first COMPUTE cycle, when bias_data is valid.
          if (input_addr == '0) bias_reg <= bias_data;
          if (state_next == S_COMPUTE) begin
            input_addr  <= input_addr + 1'b1;
            weight_addr <= wnext;
            wnext       <= wnext + 1'b1;
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
        end
        S_ADD_BIAS: begin
          acc <= acc_add(acc, bias_acc);
        end
        S_COMPARE: begin
          if (!abort) begin
            score_valid <= 1'b1;
            score_class <= cls;
            score       <= acc;
            run_best    <= best_next;
            run_class   <= class_next;
            if (last_class) begin
              inference_done  <= 1'b1;
              predicted_class <= class_next;
              best_score      <= best_next;
            end else begin
              cls       <= cls + 1'b1;
              bias_addr <= cls + 1'b1;
            end
          end
        end
        S_DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inference_param.sv
// Randomised scoreboard bench for inference_param (small geometry, ACC_W=16; honours INFER_SATURATE_EN).
module tb_inference_param;

  localparam int NC  = 5;
  localparam int NI  = 7;
  localparam int WW  = 8;
  localparam int PXW = 8;
  localparam int BW  = 12;
  localparam int AW  = 16;
  localparam int PER = NI + 6;
  localparam int WAW = $clog2(NC*NI);
  localparam int CLW = $clog2(NC);
  localparam int INW = $clog2(NI);

  logic           clk = 1'b0;
  logic           rst;
  logic           weights_ready;
  logic           start;
  logic           abort;
  logic [WAW-1:0] weight_addr;
  logic [WW-1:0]  weight_data = '0;
  logic [CLW-1:0] bias_addr;
  logic [BW-1:0]  bias_data = '0;
  logic [INW-1:0] input_addr;
  logic [PXW-1:0] input_pixel = '0;
  logic           busy;
  logic           inference_done;
  logic [CLW-1:0] predicted_class;
  logic [AW-1:0]  best_score;
  logic           score_valid;
  logic [CLW-1:0] score_class;
  logic [AW-1:0]  score;

  inference_param #(
    .NUM_CLASSES(NC),
    .NUM_INPUTS (NI),
    .WEIGHT_W   (WW),
    .PIXEL_W    (PXW),
    .BIAS_W     (BW),
    .ACC_W      (AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .weights_ready  (weights_ready),
    .start          (start),
    .abort          (abort),
    .weight_addr    (weight_addr),
    .weight_data    (weight_data),
    .bias_addr      (bias_addr),
    .bias_data      (bias_data),
    .input_addr     (input_addr),
    .input_pixel    (input_pixel),
    .busy           (busy),
    .inference_done (inference_done),
    .predicted_class(predicted_class),
    .best_score     (best_score),
    .score_valid    (score_valid),
    .score_class    (score_class),
    .score          (score)
  );

  always #5 clk = ~clk;

  int wmem [NC*NI];
  int bmem [NC];
  int pmem [NI];

  always @(posedge clk) begin
    weight_data <= WW'(wmem[weight_addr]);
    bias_data   <= BW'(bmem[bias_addr]);
    input_pixel <= PXW'(pmem[input_addr]);
  end

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;
  int ndone  = 0;

  typedef struct {
    int     cls;
    longint val;
    longint at;
  } exp_t;

  exp_t sq[$];
  exp_t dq[$];

  longint exp_sc [NC];
  int     exp_pred;
  longint exp_best;
  int     last_pred = 0;
  longint last_best = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
  endfunction

  // Bring a wide value into the ACC_W range the way the engine's arithmetic does.
  function automatic longint fit(input longint v);
    longint lim;
    longint r;
    lim = longint'(1) <<< (AW - 1);
`ifdef INFER_SATURATE_EN
    if (v > lim - 1) return lim - 1;
    if (v < -lim)    return -lim;
    return v;
`else
    r = v & ((lim <<< 1) - 1);
    if (r >= lim) r = r - (lim <<< 1);
    return r;
`endif
  endfunction

  function automatic void run_model();
    longint a;
    for (int c = 0; c < NC; c++) begin
      a = 0;
      for (int i = 0; i < NI; i++) a = fit(a + longint'(wmem[c*NI+i]) * longint'(pmem[i]));
      exp_sc[c] = fit(a + longint'(bmem[c]));
    end
    exp_pred = 0;
    exp_best = exp_sc[0];
    for (int c = 1; c < NC; c++)
      if (exp_sc[c] > exp_best) begin
        exp_pred = c;
        exp_best = exp_sc[c];
      end
  endfunction

  // mode: 0 random, 1 ones with stepped bias, 2 zero weights / equal bias, 3 -1/0/+1 rows, 4 extreme
  task automatic fill(input int mode);
    for (int c = 0; c < NC; c++) begin
      for (int i = 0; i < NI; i++) begin
        case (mode)
          1:       wmem[c*NI+i] = 1;
          2:       wmem[c*NI+i] = 0;
          3:       wmem[c*NI+i] = (c % 3) - 1;
          4:       wmem[c*NI+i] = (c % 2 == 0) ? 127 : -128;
          default: wmem[c*NI+i] = int'($urandom_range(0, 255)) - 128;
        endcase
      end
      case (mode)
        1:       bmem[c] = 500 * c;
        2:       bmem[c] = 5;
        3:       bmem[c] = 0;
        4:       bmem[c] = (c % 2 == 0) ? 0 : -2048;
        default: bmem[c] = int'($urandom_range(0, 4095)) - 2048;
      endcase
    end
    for (int i = 0; i < NI; i++) begin
      case (mode)
        1:       pmem[i] = 1;
        3, 4:    pmem[i] = 255;
        default: pmem[i] = int'($urandom_range(0, 255));
      endcase
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (score_valid) begin
        if (sq.size() == 0) begin
          total++;
          $display("FAIL unexpected_score_valid class=%0d score=%0d", score_class, $signed(score));
        end else begin
          e = sq.pop_front();
          check("score_class", longint'(score_class), e.cls);
          check("score_value", $signed(score), e.val);
          check("score_cycle", cyc, e.at);
        end
      end
      if (inference_done) begin
        ndone++;
        if (dq.size() == 0) begin
          total++;
          $display("FAIL unexpected_done predicted=%0d", predicted_class);
        end else begin
          e = dq.pop_front();
          check("done_class", longint'(predicted_class), e.cls);
          check("done_score", $signed(best_score), e.val);
          check("done_cycle", cyc, e.at);
          check("busy_in_done", longint'(busy), 1);
        end
      end
    end
  end

  // abort_at > 0: abort is sampled on that edge counted from the start edge.
  task automatic launch(input int abort_at, input bit mid_start);
    longint t0;
    int     n0;
    int     waited;
    run_model();
    n0 = ndone;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    for (int c = 0; c < NC; c++)
      if (abort_at == 0 || (c + 1) * PER < abort_at)
        sq.push_back('{c, exp_sc[c], t0 + longint'((c + 1) * PER)});
    if (abort_at == 0) dq.push_back('{exp_pred, exp_best, t0 + longint'(NC * PER)});

    if (abort_at > 0) begin
      repeat (abort_at - 1) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy_low", longint'(busy), 0);
      check("abort_keeps_class", longint'(predicted_class), last_pred);
      check("abort_keeps_score", $signed(best_score), last_best);
      repeat (NC * PER) @(negedge clk);
      check("abort_no_done", ndone - n0, 0);
      check("abort_scores_drained", sq.size(), 0);
      sq.delete();
    end else begin
      waited = 0;
      if (mid_start) begin
        repeat (PER + 3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited = PER + 4;
      end
      while (ndone == n0 && waited < NC * PER + 20) begin
        @(negedge clk);
        waited++;
      end
      check("done_seen", ndone - n0, 1);
      @(negedge clk);
      check("idle_after_done", longint'(busy), 0);
      check("hold_input_addr", longint'(input_addr), NI - 1);
      check("hold_bias_addr", longint'(bias_addr), NC - 1);
      check("hold_weight_addr", longint'(weight_addr), NC * NI - 1);
      last_pred = exp_pred;
      last_best = exp_best;
    end
  endtask

  task automatic expect_idle(input string name, input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      check(name, longint'(busy), 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    weights_ready = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    fill(2);
    repeat (3) @(negedge clk);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(inference_done), 0);
    check("rst_pred", longint'(predicted_class), 0);
    check("rst_best", longint'(best_score), 0);
    check("rst_score_valid", longint'(score_valid), 0);
    check("rst_score_class", longint'(score_class), 0);
    check("rst_score", longint'(score), 0);
    check("rst_weight_addr", longint'(weight_addr), 0);
    check("rst_bias_addr", longint'(bias_addr), 0);
    check("rst_input_addr", longint'(input_addr), 0);
    rst = 1'b0;

    // start without loaded memories is ignored
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    expect_idle("start_not_ready", 3);
    weights_ready = 1'b1;

    // abort beats start in IDLE
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    expect_idle("start_with_abort", 3);

    fill(1); launch(0, 1'b0);
    fill(2); launch(0, 1'b0);
    fill(3); launch(0, 1'b1);
    fill(4); launch(0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      fill(0);
      launch(0, k[0]);
    end

    fill(1); launch(0, 1'b0);
    fill(0); launch(2 * PER, 1'b0);
    launch(0, 1'b0);
    fill(0); launch(3, 1'b0);
    fill(0); launch(0, 1'b0);

    repeat (5) @(negedge clk);
    check("score_queue_empty", sq.size(), 0);
    check("done_queue_empty", dq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/inference_param.md
# inference_param

Parametrised successor to the fixed 10×784 linear-classifier inference engine. Computes `score[c] = bias[c] + Σ weight[c][i]·pixel[i]` for every class over synchronous weight, bias and pixel memories, then reports the arg-max class and its score. It adds a per-class score stream and a synchronous abort, and sits between the weight/bias loader memories and the digit display/UART result path.

## Interface
Parameters:
- NUM_CLASSES, 10, number of output classes (≥2)
- NUM_INPUTS, 784, input vector length (≥2)
- WEIGHT_W, 8, signed weight width
- PIXEL_W, 8, unsigned pixel width
- BIAS_W, 32, signed bias width (≤ ACC_W)
- ACC_W, 32, signed accumulator/score width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- weights_ready  in  1  memories loaded; start ignored while low
- start  in  1  begin inference, sampled in IDLE only
- abort  in  1  cancel a running inference
- weight_addr  out  clog2(NUM_CLASSES·NUM_INPUTS)  class-major address c·NUM_INPUTS+i
- weight_data  in  WEIGHT_W  signed, valid 1 cycle after address
- bias_addr  out  clog2(NUM_CLASSES)  class index
- bias_data  in  BIAS_W  signed, valid 1 cycle after address
- input_addr  out  clog2(NUM_INPUTS)  pixel index
- input_pixel  in  PIXEL_W  unsigned, valid 1 cycle after address
- busy  out  1  high from start acceptance until the DONE cycle inclusive
- inference_done  out  1  one-cycle pulse
- predicted_class  out  clog2(NUM_CLASSES)  arg-max of the last completed run
- best_score  out  ACC_W  score of predicted_class
- score_valid  out  1  one-cycle pulse per class
- score_class  out  clog2(NUM_CLASSES)  class of current score
- score  out  ACC_W  final score of score_class

## Operation
- States: IDLE → LOAD_BIAS → COMPUTE → DRAIN → ADD_BIAS → COMPARE → (LOAD_BIAS for the next class | DONE) → IDLE.
- IDLE: start && weights_ready && !abort moves to LOAD_BIAS with class=0.
- LOAD_BIAS (1 cycle): drive bias_addr=class. Clear accumulator, weight_reg, pixel_reg, product and all pipeline valid bits.
- COMPUTE (NUM_INPUTS cycles): issue i=0..N-1, one per cycle, on input_addr and weight_addr. bias_data is captured on the first COMPUTE cycle.
- Pipeline: address issued → operands registered (+1) → product registered (+2) → accumulated (+3). Exactly NUM_INPUTS products are accumulated per class, with no carry-over between classes.
- DRAIN (3 cycles): no new addresses; the pipeline empties.
- ADD_BIAS (1 cycle): acc += sign-extended bias.
- COMPARE (1 cycle):
  - Pulse score_valid with score_class and score.
  - Class 0 loads best unconditionally. Later classes replace best only on strictly greater signed score, so ties keep the lower index.
  - If this is the last class, go to DONE; otherwise increment class and go to LOAD_BIAS.
- DONE (1 cycle): pulse inference_done, update predicted_class and best_score, return to IDLE.
- Arithmetic:
  - Pixel is zero-extended and weight sign-extended.
  - Product is signed, WEIGHT_W+PIXEL_W+1 bits, sign-extended to ACC_W.
  - Sums wrap modulo 2^ACC_W (see Configuration).
- abort, in any non-IDLE state, returns to IDLE on the next edge:
  - No done pulse and no further score_valid pulses.
  - predicted_class and best_score keep the previous completed result.
- In IDLE, abort beats start. start while busy is ignored.

## Timing
- Reset: all outputs 0, state IDLE, all internal registers 0.
- Per class: NUM_INPUTS+6 cycles.
- If the edge sampling start is edge 0, inference_done is high after edge NUM_CLASSES·(NUM_INPUTS+6).
- score_valid for class c is high after edge (c+1)·(NUM_INPUTS+6).
- predicted_class and best_score change only in the DONE cycle.
- Address outputs hold their last value outside COMPUTE/LOAD_BIAS.
- Memories are single-cycle synchronous reads; there is no backpressure.

## Configuration
- INFER_SATURATE_EN defined: accumulate and bias add saturate to [−2^(ACC_W−1), 2^(ACC_W−1)−1]. Once saturated, a value stays clamped until opposite-sign terms pull it back in range.
- INFER_SATURATE_EN undefined: two's-complement wrap, no extra logic.

## Test plan
- Defaults; all weights 1, pixels 1, bias[c]=1000·c → predicted_class=9, best_score=9784, done exactly 7900 cycles after start, 784 weight addresses per class.
- NUM_CLASSES=3, NUM_INPUTS=4; weights −1/0/+1 for classes 0/1/2; pixels 255; bias 0 → score_valid pulses with −1020, 0, 1020 in class order; predicted_class=2.
- All weights 0, all biases 5 → predicted_class=0 (tie to lowest index), best_score=5.
- Complete a run (result 9), then start again and assert abort 100 cycles in → busy low next cycle, no done, predicted_class stays 9. A subsequent start completes correctly.
- ACC_W=16, NUM_INPUTS=4, weights 127, pixels 255, bias 0 → score 32767 with INFER_SATURATE_EN, −1532 without.
- start with weights_ready=0, and start pulsed mid-run → both ignored; run timing unchanged; start+abort together in IDLE → stays IDLE.
